mux8way_tdm: RTL

MUX8WAY_TDM -- requirements
Module: mux8way_tdm

---
 rtl/mux8way_pkg.sv | 28 ++
 rtl/rr_arbiter8.sv | 26 ++
 rtl/mux8way_tdm.sv | 83 ++++++++
 3 files changed

// File: rtl/mux8way_pkg.sv
// Shared constants and state encoding for the 8-way TDM mux.
// Small helpers used by the arbiter and the top level.
package mux8way_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] next_ptr(
    input logic [SEL_W-1:0] g
  );
    return g + SEL_W'(1);
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(
    input logic [SEL_W-1:0] idx
  );
    logic [NUM_CH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational round-robin search over 8 requesters.
// Grant is the first valid channel at or after ptr, modulo 8.
module rr_arbiter8
  import mux8way_pkg::*;
(
  input  logic [NUM_CH-1:0] valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              any
);

  // Walk from the far end so the nearest hit wins.
  always_comb begin
    grant = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      logic [SEL_W-1:0] idx;
      idx = ptr + SEL_W'(i);
      if (valid[idx]) begin
        grant = idx;
      end
    end
  end

  assign any = |valid;

endmodule

// File: rtl/mux8way_tdm.sv
// 8-to-1 time-division mux: round-robin merge of valid/ready
// channels into one registered stream tagged with its source.
module mux8way_tdm
  import mux8way_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] grant;
  logic             any;
  logic             load;
  logic             take;

  rr_arbiter8 u_arb (
    .valid (in_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (any)
  );

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign load      = !out_valid || out_ready;

  // Reset gates take so in_ready drops without waiting for clk.
  assign take     = load && any && !reset;
  assign in_ready = take ? onehot(grant) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (take) begin
      data_d = in_data[grant*WIDTH +: WIDTH];
      sel_d  = grant;
      ptr_d  = next_ptr(grant);
    end
    unique case (state_q)
      EMPTY: begin
        if (take) state_d = FULL;
      end
      FULL: begin
        if (out_ready && !any) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

endmodule
